// File: rtl/coin_change_seq.sv
// Greedy, inventory-aware coin change decomposer: one subtraction or one slot advance per clock.
// Optional COIN_STROBE_EN adds a one-hot per-coin strobe on every subtraction edge.
module coin_change_seq #(
    parameter int AMT_W  = 9,
    parameter int CNT_W  = 4,
    parameter int DENOM0 = 100,
    parameter int DENOM1 = 25,
    parameter int DENOM2 = 10,
    parameter int DENOM3 = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [AMT_W-1:0]   amount_i,
    input  logic [4*CNT_W-1:0] inv_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               ok_o,
    output logic               err_o,
    output logic [4*CNT_W-1:0] counts_o,
    output logic [AMT_W-1:0]   remainder_o,
    output logic [3:0]         coin_stb_o
);
    typedef enum logic {IDLE, CALC} state_t;

    localparam logic [AMT_W-1:0] DENOM [4] = '{AMT_W'(DENOM0), AMT_W'(DENOM1),
                                               AMT_W'(DENOM2), AMT_W'(DENOM3)};

    state_t                  state, state_n;
    logic [AMT_W-1:0]        rem, rem_n;
    logic [3:0][CNT_W-1:0]   cnt, cnt_n, inv, inv_n;
    logic [2:0]              idx, idx_n;
    logic                    ok, ok_n, err, err_n, done, done_n;
    logic [3:0]              stb_n;
    logic [1:0]              slot;

    assign slot = idx[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
            cnt   <= '0;
            inv   <= '0;
            idx   <= '0;
            ok    <= 1'b0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            cnt   <= cnt_n;
            inv   <= inv_n;
            idx   <= idx_n;
            ok    <= ok_n;
            err   <= err_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        cnt_n   = cnt;
        inv_n   = inv;
        idx_n   = idx;
        ok_n    = ok;
        err_n   = err;
        done_n  = 1'b0;
        stb_n   = '0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    rem_n   = amount_i;
                    inv_n   = inv_i;
                    cnt_n   = '0;
                    idx_n   = '0;
                    ok_n    = 1'b0;
                    err_n   = 1'b0;
                    state_n = CALC;
                end
            end
            CALC: begin
                if (rem == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    ok_n    = 1'b1;
                end else if (idx == 3'd4) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                // a slot is abandoned on shortfall, empty inventory or a saturated count
                end else if (rem >= DENOM[slot] && cnt[slot] < inv[slot] && cnt[slot] != '1) begin
                    rem_n       = rem - DENOM[slot];
                    cnt_n[slot] = cnt[slot] + CNT_W'(1);
                    stb_n[slot] = 1'b1;
                end else begin
                    idx_n = idx + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef COIN_STROBE_EN
    logic [3:0] stb;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stb <= '0;
        else        stb <= stb_n;
    end
    assign coin_stb_o = stb;
`else
    logic unused_stb;
    assign unused_stb = ^stb_n;
    assign coin_stb_o = '0;
`endif

    assign busy_o      = (state == CALC);
    assign done_o      = done;
    assign ok_o        = ok;
    assign err_o       = err;
    assign counts_o    = cnt;
    assign remainder_o = rem;

endmodule

// File: tb/tb_coin_change_seq.sv
// Directed bench for coin_change_seq: a greedy min()-based model predicts counts, remainder and latency.
module tb_coin_change_seq;
    localparam int AMT_W = 9;
    localparam int CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start_i = 1'b0;
    logic [AMT_W-1:0]   amount_i = '0;
    logic [4*CNT_W-1:0] inv_i = '0;
    logic               busy_o, done_o, ok_o, err_o;
    logic [4*CNT_W-1:0] counts_o;
    logic [AMT_W-1:0]   remainder_o;
    logic [3:0]         coin_stb_o;

    coin_change_seq #(.AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .amount_i(amount_i), .inv_i(inv_i),
        .busy_o(busy_o), .done_o(done_o), .ok_o(ok_o), .err_o(err_o),
        .counts_o(counts_o), .remainder_o(remainder_o), .coin_stb_o(coin_stb_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int runs_done = 0;
    int last_l = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Greedy reference: take as many of each coin as amount, stock and counter width allow.
    task automatic model(input int amt, input logic [4*CNT_W-1:0] inv,
                         output int cnt[4], output int rem, output int lat);
        int d[4] = '{100, 25, 10, 5};
        int subs = 0, adv = 0, n;
        rem = amt;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        for (int k = 0; k < 4; k++) begin
            if (rem == 0) break;
            n = rem / d[k];
            if (n > int'(inv[k*CNT_W +: CNT_W])) n = int'(inv[k*CNT_W +: CNT_W]);
            if (n > 15) n = 15;
            cnt[k] = n;
            rem -= n * d[k];
            subs += n;
            if (rem != 0) adv++;
        end
        lat = subs + adv + 1;
    endtask

    // Per-cycle compare against the model; e counts edges since the accepting edge.
    bit active = 0, have_res = 0, exp_ok = 0;
    int e = 0, exp_l = 0, exp_rem = 0;
    int exp_cnt[4];
    int stb_cnt[4];
    logic [4*CNT_W-1:0] exp_counts;

    always @(negedge clk) begin
        if (!rst_n) begin
            active   = 0;
            have_res = 0;
            chk("rst_busy", busy_o, 0);
            chk("rst_done", done_o, 0);
            chk("rst_ok", ok_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_counts", counts_o, 0);
            chk("rst_rem", remainder_o, 0);
            chk("rst_stb", coin_stb_o, 0);
        end else begin
            if (active) e++;
            if (active && e > exp_l) active = 0;
`ifdef COIN_STROBE_EN
            chk("stb_onehot0", ($countones(coin_stb_o) <= 1), 1);
            if (active) for (int k = 0; k < 4; k++) if (coin_stb_o[k]) stb_cnt[k]++;
`else
            chk("stb_off", coin_stb_o, 0);
`endif
            if (active) begin
                chk("busy", busy_o, (e < exp_l));
                chk("done", done_o, (e == exp_l));
                if (e == exp_l) begin
                    chk("res_ok", ok_o, exp_ok);
                    chk("res_err", err_o, !exp_ok);
                    chk("res_counts", counts_o, exp_counts);
                    chk("res_rem", remainder_o, exp_rem);
`ifdef COIN_STROBE_EN
                    for (int k = 0; k < 4; k++) chk("stb_pulses", stb_cnt[k], exp_cnt[k]);
`endif
                    have_res = 1;
                    runs_done++;
                end
            end else begin
                chk("idle_busy", busy_o, 0);
                chk("idle_done", done_o, 0);
                if (have_res) begin
                    chk("hold_ok", ok_o, exp_ok);
                    chk("hold_err", err_o, !exp_ok);
                    chk("hold_counts", counts_o, exp_counts);
                    chk("hold_rem", remainder_o, exp_rem);
                end
            end
            if (start_i && (!active || e == exp_l)) begin
                model(int'(amount_i), inv_i, exp_cnt, exp_rem, exp_l);
                exp_ok = (exp_rem == 0);
                for (int k = 0; k < 4; k++) begin
                    exp_counts[k*CNT_W +: CNT_W] = CNT_W'(exp_cnt[k]);
                    stb_cnt[k] = 0;
                end
                last_l = exp_l;
                active = 1;
                e = -1;
            end
        end
    end

    task automatic wait_runs(input int target);
        for (int i = 0; i < 200; i++) begin
            if (runs_done >= target) return;
            @(posedge clk);
        end
        chk("timeout_done", runs_done, target);
    endtask

    task automatic run(input int amt, input logic [4*CNT_W-1:0] inv);
        int tgt;
        @(posedge clk); #1;
        start_i  = 1'b1;
        amount_i = AMT_W'(amt);
        inv_i    = inv;
        tgt      = runs_done + 1;
        @(posedge clk); #1;
        start_i  = 1'b0;
        amount_i = AMT_W'($urandom);
        inv_i    = 16'($urandom);
        wait_runs(tgt);
        @(posedge clk); #1;
    endtask

    localparam logic [15:0] FULL = 16'hFFFF;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // abort mid-run: 4th CALC cycle
        @(posedge clk); #1;
        start_i = 1'b1; amount_i = 9'd190; inv_i = FULL;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_o, 0);
        chk("abort_counts", counts_o, 0);
        chk("abort_rem", remainder_o, 0);
        chk("abort_done", done_o, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        run(190, FULL);
        chk("p190_lat", last_l, 10);
        chk("p190_counts", counts_o, 16'h1131);
        chk("p190_ok", ok_o, 1);

        run(0, FULL);
        chk("p0_lat", last_l, 1);
        chk("p0_counts", counts_o, 0);

        run(3, FULL);
        chk("p3_lat", last_l, 5);
        chk("p3_rem", remainder_o, 3);
        chk("p3_err", err_o, 1);

        run(60, {4'd0, 4'd2, 4'd1, 4'd0});
        chk("p60_lat", last_l, 8);
        chk("p60_counts", counts_o, 16'h0210);
        chk("p60_rem", remainder_o, 15);

        // nickel count saturates at 15
        run(95, {4'd15, 4'd0, 4'd0, 4'd0});
        chk("sat_counts", counts_o, 16'hF000);
        chk("sat_rem", remainder_o, 20);

        run(511, FULL);
        chk("p511_counts", counts_o, 16'h0105);
        chk("p511_rem", remainder_o, 1);

        // start held high: re-accepted in the done cycle
        begin
            int tgt;
            @(posedge clk); #1;
            start_i = 1'b1; amount_i = 9'd25; inv_i = FULL;
            tgt = runs_done + 1;
            wait_runs(tgt);
            #1;
            chk("restart_busy", busy_o, 1);
            start_i = 1'b0;
            chk("p25_lat", last_l, 3);
            wait_runs(tgt + 1);
            @(posedge clk); #1;
            chk("p25_counts", counts_o, 16'h0010);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
